fix_trailer_gen: RTL and testbench
==================================

FIX_TRAILER_GEN -- requirements
Module: fix_trailer_gen

Interface
REQ-001 SHALL have parameter SOH_CHAR, default 8'h01, field delimiter byte emitted as the final trailer byte.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low (rst==0 resets on the clock edge).
REQ-004 SHALL have port in_data_i  input  8  outgoing body byte, from "8=" through the SOH preceding the checksum field.
REQ-005 SHALL have port in_valid_i  input  1  in_data_i valid.
REQ-006 SHALL have port in_last_i  input  1  marks the final body byte of a message.
REQ-007 SHALL have port in_ready_o  output  1  block accepts the input byte this cycle.
REQ-008 SHALL have port out_data_o  output  8  transmitted byte (body pass-through, then trailer).
REQ-009 SHALL have port out_valid_o  output  1  out_data_o valid.
REQ-010 SHALL have port out_last_o  output  1  marks the trailer SOH byte.
REQ-011 SHALL have port out_ready_i  input  1  downstream accepts out_data_o.
REQ-012 SHALL have port checksum_o  output  8  checksum of the most recently completed message.
REQ-013 SHALL have port checksum_valid_o  output  1  one-cycle pulse when a trailer completes.
REQ-014 SHALL have port busy_o  output  1  high from the first accepted body byte until the trailer SOH is accepted.

Function
REQ-015 SHALL accept an input byte only when in_valid_i and in_ready_o are both high; output transfer occurs only when out_valid_o and out_ready_i are both high.
REQ-016 SHALL have a single output register; in_ready_o = (state==BODY) and (!out_valid_o or out_ready_i).
REQ-017 SHALL present an accepted body byte on out_data_o exactly one cycle after acceptance, unmodified.
REQ-018 SHALL hold out_data_o, out_valid_o and out_last_o stable while out_valid_o=1 and out_ready_i=0.
REQ-019 SHALL accumulate an 8-bit sum of every accepted body byte, including the in_last_i byte; carries are discarded (modulo 256).
REQ-020 SHALL implement states BODY and TRAILER, with a 3-bit trailer index from 0 to 6.
REQ-021 BODY->TRAILER SHALL occur on acceptance of a byte with in_last_i=1; the final sum is then frozen for that message.
REQ-022 In TRAILER, one trailer byte SHALL be loaded per cycle whenever the output register is empty or being consumed, in this order: 8'h31, 8'h30, 8'h3D, hundreds digit, tens digit, units digit, SOH_CHAR.
REQ-023 Each digit SHALL be 8'h30 plus the decimal digit of the final sum (0-255), always three digits with zero padding; digit extraction SHALL use compare/subtract logic, not a divider.
REQ-024 out_last_o SHALL be 1 only with the SOH_CHAR trailer byte.
REQ-025 After the SOH_CHAR byte is loaded, the block SHALL return to BODY with sum=0 and index=0.
REQ-026 With out_ready_i held at 1, the output stream SHALL have no bubbles; in_ready_o SHALL be low for exactly 7 cycles per message.
REQ-027 When the SOH_CHAR byte is accepted downstream, checksum_o SHALL update to the final sum and checksum_valid_o SHALL pulse for that same cycle.
REQ-028 In TRAILER, in_valid_i SHALL be ignored and no input byte SHALL be consumed.
REQ-029 A single-byte message (first byte has in_last_i=1) SHALL be legal.

Reset
REQ-030 While rst=0 at a clock edge, the following SHALL be set: state=BODY, index=0, sum=0, out_valid_o=0, out_last_o=0, out_data_o=8'h00, checksum_o=8'h00, checksum_valid_o=0, busy_o=0.
REQ-031 A reset applied mid-body or mid-trailer SHALL abandon the message with no trailer emitted; the next message's sum SHALL start from 0.
REQ-032 in_ready_o SHALL be 0 while rst=0 and SHALL be 1 on the first cycle after reset is released.

Verification
REQ-033 Body 38 3D 41 01 (last on 01), out_ready_i=1 -> output 38 3D 41 01 31 30 3D 31 38 33 01 with no gaps, out_last_o on the final 01, checksum_o=8'hB7 (183).
REQ-034 Single byte 00 with last -> trailer 31 30 3D 30 30 30 01, checksum_o=0, one checksum_valid_o pulse.
REQ-035 Body FF 02 (last) -> sum wraps to 1 -> trailer digits 30 30 31.
REQ-036 out_ready_i low for 5 cycles while the tens digit is presented -> out_data_o stable throughout, and no trailer byte is lost or duplicated.
REQ-037 rst=0 asserted for 1 cycle during trailer index 2 -> out_valid_o=0 the next cycle, and the following message 41 (last) yields trailer digits 30 36 35.
REQ-038 Two back-to-back messages with out_ready_i=1 -> in_ready_o low exactly 7 cycles between them, and the second checksum is independent of the first.

Source files
------------

// File: rtl/fix_trailer_gen.sv
// FIX trailer generator: passes message body through and appends the
// "10=NNN<SOH>" checksum field computed over the body bytes.
module fix_trailer_gen #(
    parameter logic [7:0] SOH_CHAR = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data_i,
    input  logic       in_valid_i,
    input  logic       in_last_i,
    output logic       in_ready_o,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    output logic       out_last_o,
    input  logic       out_ready_i,
    output logic [7:0] checksum_o,
    output logic       checksum_valid_o,
    output logic       busy_o
);

    typedef enum logic {BODY, TRAILER} state_e;

    state_e     state_q;
    logic [2:0] idx_q;
    logic [7:0] sum_q;
    logic [7:0] fin_q;
    logic [7:0] out_data_q;
    logic       out_valid_q;
    logic       out_last_q;
    logic [7:0] chk_q;
    logic       chk_v_q;
    logic       busy_q;

    logic       load_en;
    logic       accept;
    logic       soh_acc;
    logic [7:0] sum_d;
    logic [1:0] hund;
    logic [7:0] rem;
    logic [3:0] tens;
    logic [7:0] tens10;
    logic [3:0] units;
    logic [7:0] tbyte;

    assign load_en    = !out_valid_q || out_ready_i;
    assign in_ready_o = rst && (state_q == BODY) && load_en;
    assign accept     = in_valid_i && in_ready_o;
    assign soh_acc    = out_valid_q && out_ready_i && out_last_q;
    assign sum_d      = sum_q + in_data_i;

    // Decimal digits by compare/subtract; sum_q is frozen during TRAILER.
    always_comb begin
        hund   = 2'd0;
        rem    = sum_q;
        tens   = 4'd0;
        tens10 = 8'd0;
        if (sum_q >= 8'd200) begin
            hund = 2'd2;
            rem  = sum_q - 8'd200;
        end else if (sum_q >= 8'd100) begin
            hund = 2'd1;
            rem  = sum_q - 8'd100;
        end
        for (int k = 1; k < 10; k++) begin
            if (rem >= 8'(k * 10)) begin
                tens   = 4'(k);
                tens10 = 8'(k * 10);
            end
        end
        units = 4'(rem - tens10);
    end

    always_comb begin
        tbyte = SOH_CHAR;
        unique case (idx_q)
            3'd0:    tbyte = 8'h31;
            3'd1:    tbyte = 8'h30;
            3'd2:    tbyte = 8'h3D;
            3'd3:    tbyte = {6'b001100, hund};
            3'd4:    tbyte = {4'h3, tens};
            3'd5:    tbyte = {4'h3, units};
            default: tbyte = SOH_CHAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= BODY;
            idx_q       <= 3'd0;
            sum_q       <= 8'h00;
            fin_q       <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            chk_q       <= 8'h00;
            chk_v_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            chk_v_q <= 1'b0;
            if (soh_acc) begin
                chk_q   <= fin_q;
                chk_v_q <= 1'b1;
            end
            if (accept) busy_q <= 1'b1;
            else if (soh_acc) busy_q <= 1'b0;

            unique case (state_q)
                BODY: begin
                    if (accept) begin
                        out_data_q  <= in_data_i;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        sum_q       <= sum_d;
                        if (in_last_i) begin
                            fin_q   <= sum_d;
                            state_q <= TRAILER;
                        end
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end
                TRAILER: begin
                    if (load_en) begin
                        out_data_q  <= tbyte;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (idx_q == 3'd6);
                        if (idx_q == 3'd6) begin
                            state_q <= BODY;
                            idx_q   <= 3'd0;
                            sum_q   <= 8'h00;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                default: state_q <= BODY;
            endcase
        end
    end

    assign out_data_o       = out_data_q;
    assign out_valid_o      = out_valid_q;
    assign out_last_o       = out_last_q;
    assign checksum_o       = chk_q;
    assign checksum_valid_o = chk_v_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_fix_trailer_gen.sv
// Directed testbench for fix_trailer_gen: body pass-through, trailer
// digits, backpressure, reset abandonment and back-to-back messages.
module tb_fix_trailer_gen;

    logic       clk;
    logic       rst;
    logic [7:0] in_data_i;
    logic       in_valid_i;
    logic       in_last_i;
    logic       in_ready_o;
    logic [7:0] out_data_o;
    logic       out_valid_o;
    logic       out_last_o;
    logic       out_ready_i;
    logic [7:0] checksum_o;
    logic       checksum_valid_o;
    logic       busy_o;

    int tests = 0;
    int fails = 0;

    logic [7:0] got[$];
    logic       gotl[$];
    int         gotc[$];
    logic [7:0] cks[$];
    int         cyc = 0;
    int         lowcnt = 0;
    int         pulses = 0;

    fix_trailer_gen #(.SOH_CHAR(8'h01)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_data_i        (in_data_i),
        .in_valid_i       (in_valid_i),
        .in_last_i        (in_last_i),
        .in_ready_o       (in_ready_o),
        .out_data_o       (out_data_o),
        .out_valid_o      (out_valid_o),
        .out_last_o       (out_last_o),
        .out_ready_i      (out_ready_i),
        .checksum_o       (checksum_o),
        .checksum_valid_o (checksum_valid_o),
        .busy_o           (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on negedge, so values seen here are the settled cycle values.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            if (!in_ready_o) lowcnt++;
            if (out_valid_o && out_ready_i) begin
                got.push_back(out_data_o);
                gotl.push_back(out_last_o);
                gotc.push_back(cyc);
            end
            if (checksum_valid_o) begin
                pulses++;
                cks.push_back(checksum_o);
            end
        end
    end

    function automatic bit q_eq(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_mon();
        got.delete();
        gotl.delete();
        gotc.delete();
        cks.delete();
        lowcnt = 0;
        pulses = 0;
    endtask

    // Called at a negedge; returns at a negedge after the last byte is taken.
    task automatic send_msg(input logic [7:0] m[$]);
        int n;
        foreach (m[i]) begin
            in_data_i  = m[i];
            in_last_i  = (i == m.size() - 1);
            in_valid_i = 1'b1;
            #1;
            n = 0;
            while (!in_ready_o && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (n >= 100) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: in_ready_o stayed %b, required 1", in_ready_o);
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_pulses(input int n, output bit to);
        int c;
        c = 0;
        while (pulses < n && c < 200) begin
            @(negedge clk);
            c++;
        end
        to = (pulses < n);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid_i = 1'b0;
        in_last_i = 1'b0;
        in_data_i = 8'h00;
        out_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({out_valid_o, out_last_o, checksum_valid_o, busy_o} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b required 0000",
                     {out_valid_o, out_last_o, checksum_valid_o, busy_o});
        end
        tests++;
        if (out_data_o !== 8'h00 || checksum_o !== 8'h00) begin
            fails++;
            $display("FAIL reset_data: out_data %h checksum %h required 00 00",
                     out_data_o, checksum_o);
        end
        tests++;
        if (in_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_low: got %b required 0", in_ready_o);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (in_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_release: got %b required 1", in_ready_o);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] exp[$];
        bit to;
        bit lastok;
        clear_mon();
        exp = '{8'h38, 8'h3D, 8'h41, 8'h01, 8'h31, 8'h30, 8'h3D,
                8'h31, 8'h38, 8'h33, 8'h01};
        send_msg('{8'h38, 8'h3D, 8'h41, 8'h01});
        in_valid_i = 1'b0;
        tests++;
        if (busy_o !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy_high: got %b required 1", busy_o);
        end
        wait_pulses(1, to);
        tests++;
        if (to || !q_eq(got, exp)) begin
            fails++;
            $display("FAIL basic_stream: got %p required %p", got, exp);
        end
        lastok = (gotl.size() == 11);
        foreach (gotl[i]) if (gotl[i] !== (i == 10)) lastok = 1'b0;
        tests++;
        if (!lastok) begin
            fails++;
            $display("FAIL basic_last: got %p required last only on byte 10", gotl);
        end
        tests++;
        if (gotc.size() != 11 || gotc[10] - gotc[0] != 10) begin
            fails++;
            $display("FAIL basic_no_gaps: got %p required 11 consecutive cycles", gotc);
        end
        tests++;
        if (checksum_o !== 8'hB7 || pulses != 1) begin
            fails++;
            $display("FAIL basic_checksum: got %h x%0d required b7 x1", checksum_o, pulses);
        end
        tests++;
        if (lowcnt != 7) begin
            fails++;
            $display("FAIL basic_ready_low: got %0d required 7", lowcnt);
        end
        tests++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL basic_busy_low: got %b required 0", busy_o);
        end
    endtask

    task automatic test_single_zero();
        logic [7:0] exp[$];
        bit to;
        clear_mon();
        exp = '{8'h00, 8'h31, 8'h30, 8'h3D, 8'h30, 8'h30, 8'h30, 8'h01};
        send_msg('{8'h00});
        in_valid_i = 1'b0;
        wait_pulses(1, to);
        tests++;
        if (to || !q_eq(got, exp)) begin
            fails++;
            $display("FAIL single_stream: got %p required %p", got, exp);
        end
        tests++;
        if (checksum_o !== 8'h00 || pulses != 1) begin
            fails++;
            $display("FAIL single_checksum: got %h x%0d required 00 x1", checksum_o, pulses);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp[$];
        bit to;
        clear_mon();
        exp = '{8'hFF, 8'h02, 8'h31, 8'h30, 8'h3D, 8'h30, 8'h30, 8'h31, 8'h01};
        send_msg('{8'hFF, 8'h02});
        in_valid_i = 1'b0;
        wait_pulses(1, to);
        tests++;
        if (to || !q_eq(got, exp)) begin
            fails++;
            $display("FAIL wrap_stream: got %p required %p", got, exp);
        end
        tests++;
        if (checksum_o !== 8'h01) begin
            fails++;
            $display("FAIL wrap_checksum: got %h required 01", checksum_o);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp[$];
        bit to;
        bit stable;
        int n;
        clear_mon();
        exp = '{8'h7B, 8'h31, 8'h30, 8'h3D, 8'h31, 8'h32, 8'h33, 8'h01};
        send_msg('{8'h7B});
        in_valid_i = 1'b0;
        #1;
        n = 0;
        while (!(out_valid_o && out_data_o == 8'h32) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        out_ready_i = 1'b0;
        stable = (n < 50);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (out_data_o !== 8'h32 || out_valid_o !== 1'b1 || out_last_o !== 1'b0)
                stable = 1'b0;
        end
        tests++;
        if (!stable) begin
            fails++;
            $display("FAIL bp_hold: got data %h valid %b last %b required 32 1 0",
                     out_data_o, out_valid_o, out_last_o);
        end
        tests++;
        if (in_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL bp_ready: got %b required 0", in_ready_o);
        end
        @(negedge clk);
        out_ready_i = 1'b1;
        wait_pulses(1, to);
        tests++;
        if (to || !q_eq(got, exp)) begin
            fails++;
            $display("FAIL bp_stream: got %p required %p", got, exp);
        end
        tests++;
        if (checksum_o !== 8'h7B) begin
            fails++;
            $display("FAIL bp_checksum: got %h required 7b", checksum_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp[$];
        logic [7:0] part[$];
        bit to;
        int n;
        clear_mon();
        part = '{8'h41, 8'h42, 8'h31};
        send_msg('{8'h41, 8'h42});
        in_valid_i = 1'b0;
        #1;
        n = 0;
        while (!(out_valid_o && out_data_o == 8'h30) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (n >= 50 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_state: got valid %b ready %b required 0 1",
                     out_valid_o, in_ready_o);
        end
        tests++;
        if (checksum_o !== 8'h00 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_clear: got checksum %h busy %b required 00 0",
                     checksum_o, busy_o);
        end
        repeat (10) @(negedge clk);
        tests++;
        if (!q_eq(got, part) || pulses != 0) begin
            fails++;
            $display("FAIL rstmid_abandon: got %p x%0d required %p x0", got, pulses, part);
        end
        clear_mon();
        exp = '{8'h41, 8'h31, 8'h30, 8'h3D, 8'h30, 8'h36, 8'h35, 8'h01};
        send_msg('{8'h41});
        in_valid_i = 1'b0;
        wait_pulses(1, to);
        tests++;
        if (to || !q_eq(got, exp) || checksum_o !== 8'h41) begin
            fails++;
            $display("FAIL rstmid_next: got %p checksum %h required %p 41",
                     got, checksum_o, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$];
        bit to;
        clear_mon();
        exp = '{8'h38, 8'h3D, 8'h41, 8'h01, 8'h31, 8'h30, 8'h3D, 8'h31,
                8'h38, 8'h33, 8'h01, 8'h41, 8'h31, 8'h30, 8'h3D, 8'h30,
                8'h36, 8'h35, 8'h01};
        send_msg('{8'h38, 8'h3D, 8'h41, 8'h01});
        send_msg('{8'h41});
        in_valid_i = 1'b0;
        wait_pulses(2, to);
        tests++;
        if (to || !q_eq(got, exp)) begin
            fails++;
            $display("FAIL b2b_stream: got %p required %p", got, exp);
        end
        tests++;
        if (lowcnt != 14) begin
            fails++;
            $display("FAIL b2b_ready_low: got %0d required 14", lowcnt);
        end
        tests++;
        if (gotc.size() != 19 || gotc[18] - gotc[0] != 18) begin
            fails++;
            $display("FAIL b2b_no_gaps: got %p required 19 consecutive cycles", gotc);
        end
        tests++;
        if (cks.size() != 2 || cks[0] !== 8'hB7 || cks[1] !== 8'h41) begin
            fails++;
            $display("FAIL b2b_checksums: got %p required b7 41", cks);
        end
    endtask

    initial begin
        rst = 1'b0;
        in_valid_i = 1'b0;
        in_last_i = 1'b0;
        in_data_i = 8'h00;
        out_ready_i = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_single_zero();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
